// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared pipeline types for the hazard/stall controller
package hazard_stall_unit_pkg;

  localparam int REG_W = 4;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    HALT     = ST_HALT
  } memState_t;

  // Register 0 is hard-wired, so it never matches as a dependency.
  function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_mem_wait_fsm.sv
// rtl/hazard_stall_unit_mem_wait_fsm.sv - data-memory wait tracking with timeout watchdog
module hazard_stall_unit_mem_wait_fsm
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic memAccess,
  input  logic memReady,
  output logic freeze,
  output logic memTimeoutErr
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  memState_t         state;
  logic [WAIT_W-1:0] waitCnt;

  always_comb begin
    freeze = 1'b0;
    unique case (state)
      RUN:      freeze = memAccess & ~memReady;
      MEM_WAIT: freeze = ~memReady;
      HALT:     freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  // The RUN cycle that first sees the stall counts as wait cycle 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      waitCnt       <= '0;
      memTimeoutErr <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (memAccess && !memReady) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (memReady) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_LAST) begin
            state         <= HALT;
            memTimeoutErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        HALT: begin
          memTimeoutErr <= 1'b1;
        end
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch stall, redirect flush and memory freeze control
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] SrcReg1_in_from_IFID,
  input  logic [REG_W-1:0] SrcReg2_in_from_IFID,
  input  logic             Src1_used_IFID,
  input  logic             Src2_used_IFID,
  input  logic             Branch_reg_IFID,
  input  logic             Branch_taken_ID,
  input  logic [REG_W-1:0] DstReg1_in_from_IDEX,
  input  logic             RegWrite_IDEX,
  input  logic             MemRead_IDEX,
  input  logic [REG_W-1:0] DstReg1_in_from_EXMEM,
  input  logic             MemRead_EXMEM,
  input  logic             MemAccess_EXMEM,
  input  logic             mem_ready,
  output logic             PC_write_en,
  output logic             IFID_write_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  logic loadUse;
  logic brHaz;
  logic stall;
  logic freeze;

  hazard_stall_unit_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) memWaitFsm (
    .clk          (clk),
    .rst          (rst),
    .memAccess    (MemAccess_EXMEM),
    .memReady     (mem_ready),
    .freeze       (freeze),
    .memTimeoutErr(mem_timeout_err)
  );

  assign loadUse = MemRead_IDEX &
                   ((Src1_used_IFID & regMatch(DstReg1_in_from_IDEX, SrcReg1_in_from_IFID)) |
                    (Src2_used_IFID & regMatch(DstReg1_in_from_IDEX, SrcReg2_in_from_IFID)));

  // A register-target branch resolves in ID, so even an ALU result in EX is too late.
  assign brHaz = Branch_reg_IFID &
                 ((RegWrite_IDEX & regMatch(DstReg1_in_from_IDEX, SrcReg1_in_from_IFID)) |
                  (MemRead_EXMEM & regMatch(DstReg1_in_from_EXMEM, SrcReg1_in_from_IFID)));

  assign stall = loadUse | brHaz;

  always_comb begin
    PC_write_en   = 1'b1;
    IFID_write_en = 1'b1;
    IFID_flush    = 1'b0;
    IDEX_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    if (rst) begin
      PC_write_en   = 1'b0;
      IFID_write_en = 1'b0;
      IFID_flush    = 1'b1;
      IDEX_flush    = 1'b1;
    end else if (freeze) begin
      PC_write_en   = 1'b0;
      IFID_write_en = 1'b0;
      pipe_freeze   = 1'b1;
    end else if (stall) begin
      PC_write_en   = 1'b0;
      IFID_write_en = 1'b0;
      IDEX_flush    = 1'b1;
    end else if (Branch_taken_ID) begin
      IFID_flush    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!PC_write_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       s1, s2, dIdex, dExmem;
  logic             u1, u2, brReg, brTaken, rwIdex, mrIdex, mrExmem, maExmem, memReady;
  logic             pcw, ifidw, ifidf, idexf, frz, err;
  logic [CNT_W-1:0] cnt;

  int checks   = 0;
  int failures = 0;
  int expCnt   = 0;

  logic [8:0] expQ[$];
  string      tagQ[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .SrcReg1_in_from_IFID (s1),
    .SrcReg2_in_from_IFID (s2),
    .Src1_used_IFID       (u1),
    .Src2_used_IFID       (u2),
    .Branch_reg_IFID      (brReg),
    .Branch_taken_ID      (brTaken),
    .DstReg1_in_from_IDEX (dIdex),
    .RegWrite_IDEX        (rwIdex),
    .MemRead_IDEX         (mrIdex),
    .DstReg1_in_from_EXMEM(dExmem),
    .MemRead_EXMEM        (mrExmem),
    .MemAccess_EXMEM      (maExmem),
    .mem_ready            (memReady),
    .PC_write_en          (pcw),
    .IFID_write_en        (ifidw),
    .IFID_flush           (ifidf),
    .IDEX_flush           (idexf),
    .pipe_freeze          (frz),
    .mem_timeout_err      (err),
    .stall_cycles         (cnt)
  );

  task automatic clr();
    s1 = 0; s2 = 0; dIdex = 0; dExmem = 0;
    u1 = 0; u2 = 0; brReg = 0; brTaken = 0; rwIdex = 0; mrIdex = 0;
    mrExmem = 0; maExmem = 0; memReady = 0; rst = 0;
  endtask

  // Expected order: PC_write_en, IFID_write_en, IFID_flush, IDEX_flush, pipe_freeze, err, count.
  task automatic chk(input string tag, input logic ePcw, input logic eIfidw, input logic eIfidf,
                     input logic eIdexf, input logic eFrz, input logic eErr);
    logic [8:0] exp;
    logic [8:0] got;
    string      t;
    expQ.push_back({ePcw, eIfidw, eIfidf, eIdexf, eFrz, eErr, CNT_W'(expCnt)});
    tagQ.push_back(tag);
    @(negedge clk);
    exp = expQ.pop_front();
    t   = tagQ.pop_front();
    got = {pcw, ifidw, ifidf, idexf, frz, err, cnt};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (pcw,ifidw,ifidf,idexf,frz,err,cnt)", t, got, exp);
    end
    if (rst) expCnt = 0;
    else if (!exp[8] && expCnt < (1 << CNT_W) - 1) expCnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    chk("reset", 0, 0, 1, 1, 0, 0);
    clr();
    chk("idle_default", 1, 1, 0, 0, 0, 0);

    mrIdex = 1; dIdex = 5; s2 = 5; u2 = 1;
    chk("load_use_src2", 0, 0, 0, 1, 0, 0);
    clr(); mrExmem = 1; dExmem = 5; s2 = 5; u2 = 1; maExmem = 1; memReady = 1;
    chk("load_in_mem_no_stall", 1, 1, 0, 0, 0, 0);

    clr(); mrIdex = 1; dIdex = 5; s1 = 5; u1 = 0;
    chk("load_src1_unused", 1, 1, 0, 0, 0, 0);
    clr(); mrIdex = 1; dIdex = 0; s1 = 0; u1 = 1;
    chk("reg0_no_hazard", 1, 1, 0, 0, 0, 0);

    clr(); brReg = 1; s1 = 3; mrExmem = 1; dExmem = 3; brTaken = 1;
    chk("br_haz_load_mem", 0, 0, 0, 1, 0, 0);
    clr(); brReg = 1; s1 = 3; brTaken = 1;
    chk("br_taken_redirect", 1, 1, 1, 0, 0, 0);
    clr(); brReg = 1; s1 = 7; rwIdex = 1; dIdex = 7;
    chk("br_haz_alu_ex", 0, 0, 0, 1, 0, 0);
    clr(); rwIdex = 1; dIdex = 7; s1 = 7; u1 = 1;
    chk("alu_dep_forwarded", 1, 1, 0, 0, 0, 0);

    clr(); maExmem = 1;
    chk("mem_wait_1", 0, 0, 0, 0, 1, 0);
    mrIdex = 1; dIdex = 9; s1 = 9; u1 = 1;
    chk("mem_wait_2_over_stall", 0, 0, 0, 0, 1, 0);
    chk("mem_wait_3", 0, 0, 0, 0, 1, 0);
    memReady = 1;
    chk("mem_ready_stall_resumes", 0, 0, 0, 1, 0, 0);
    clr();
    chk("after_mem_default", 1, 1, 0, 0, 0, 0);

    clr(); maExmem = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) chk($sformatf("timeout_freeze_%0d", i), 0, 0, 0, 0, 1, 0);
    clr(); memReady = 1;
    for (int i = 0; i < 3; i++) chk($sformatf("halt_%0d", i), 0, 0, 0, 0, 1, 1);
    rst = 1;
    chk("rst_in_halt", 0, 0, 1, 1, 0, 1);
    clr();
    chk("after_halt_rst", 1, 1, 0, 0, 0, 0);

    maExmem = 1;
    chk("wait_a", 0, 0, 0, 0, 1, 0);
    chk("wait_b", 0, 0, 0, 0, 1, 0);
    rst = 1;
    chk("rst_in_mem_wait", 0, 0, 1, 1, 0, 0);
    clr();
    chk("after_wait_rst", 1, 1, 0, 0, 0, 0);
    maExmem = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) chk($sformatf("retimeout_freeze_%0d", i), 0, 0, 0, 0, 1, 0);
    chk("retimeout_halt", 0, 0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
